// File: rtl/jtt_pkg.sv
// Shared defaults and FSM encoding for the jump target table and its clear sequencer.
package jtt_pkg;

  localparam int unsigned JTT_ADDR_W   = 5;
  localparam int unsigned JTT_TGT_W    = 12;
  localparam int unsigned JTT_MISS_TGT = 0;

  typedef enum logic [0:0] {
    JTT_CLEAR = 1'b0,
    JTT_READY = 1'b1
  } jtt_state_e;

endpackage

// File: rtl/jtt_clear_seq.sv
// Walks an index across every table entry, one per cycle; done_c marks the last entry.
module jtt_clear_seq #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic              active,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              done_c
);

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      clr_idx <= '0;
    end else if (active) begin
      clr_idx <= ADDR_W'(clr_idx + 1'b1);
    end
  end

  assign done_c = active && !restart && (clr_idx == '1);

endmodule

// File: rtl/jump_target_table.sv
// Loader-programmed label-index to PC-target table with hardware clear and write forwarding.
// Optional segment base offset on hits is enabled with `define JTT_SEG_OFFSET_EN.
module jump_target_table
  import jtt_pkg::*;
#(
  parameter int unsigned       ADDR_W   = JTT_ADDR_W,
  parameter int unsigned       TGT_W    = JTT_TGT_W,
  parameter logic [TGT_W-1:0]  MISS_TGT = TGT_W'(JTT_MISS_TGT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [TGT_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [TGT_W-1:0]  rd_target,
  output logic              rd_hit,
  output logic              busy
`ifdef JTT_SEG_OFFSET_EN
  ,
  input  logic              base_wr,
  input  logic [TGT_W-1:0]  base_data
`endif
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  jtt_state_e        state_q, state_d;
  logic              restart_c;
  logic              clearing_c;
  logic              done_c;
  logic              wr_acc_c;
  logic              fwd_c;
  logic [ADDR_W-1:0] clr_idx;
  logic [DEPTH-1:0]  valid_q;
  logic [TGT_W-1:0]  data_q [DEPTH];
  logic [TGT_W-1:0]  base_c;
  logic [TGT_W-1:0]  tgt_c;
  logic              hit_c;

  assign clearing_c = (state_q == JTT_CLEAR);
  // Flush wins over a same-cycle write.
  assign wr_acc_c   = wr_en && wr_ready && !flush;
  assign fwd_c      = wr_acc_c && (wr_addr == rd_addr);

`ifdef JTT_SEG_OFFSET_EN
  logic [TGT_W-1:0] base_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      base_q <= '0;
    end else if (base_wr) begin
      base_q <= base_data;
    end
  end

  assign base_c = base_wr ? base_data : base_q;
`else
  assign base_c = '0;
`endif

  jtt_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk     (clk),
    .reset   (reset),
    .restart (restart_c),
    .active  (clearing_c),
    .clr_idx (clr_idx),
    .done_c  (done_c)
  );

  // Next-state logic; any flush (re)starts the clear walk from entry 0.
  always_comb begin
    state_d   = state_q;
    restart_c = 1'b0;
    case (state_q)
      JTT_CLEAR: begin
        if (flush) begin
          restart_c = 1'b1;
        end else if (done_c) begin
          state_d = JTT_READY;
        end
      end
      JTT_READY: begin
        if (flush) begin
          state_d   = JTT_CLEAR;
          restart_c = 1'b1;
        end
      end
      default: state_d = JTT_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= JTT_CLEAR;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy     <= (state_d == JTT_CLEAR);
      wr_ready <= (state_d == JTT_READY);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (clearing_c) begin
      valid_q[clr_idx] <= 1'b0;
    end else if (wr_acc_c) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clearing_c) begin
      data_q[clr_idx] <= '0;
    end else if (wr_acc_c) begin
      data_q[wr_addr] <= wr_data;
    end
  end

  // Lookup: misses never get the base offset; a same-address write is forwarded.
  always_comb begin
    tgt_c = rd_target;
    hit_c = rd_hit;
    if (rd_en) begin
      if (clearing_c) begin
        tgt_c = MISS_TGT;
        hit_c = 1'b0;
      end else if (fwd_c) begin
        tgt_c = TGT_W'(wr_data + base_c);
        hit_c = 1'b1;
      end else if (valid_q[rd_addr]) begin
        tgt_c = TGT_W'(data_q[rd_addr] + base_c);
        hit_c = 1'b1;
      end else begin
        tgt_c = MISS_TGT;
        hit_c = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_target <= '0;
      rd_hit    <= 1'b0;
    end else begin
      rd_target <= tgt_c;
      rd_hit    <= hit_c;
    end
  end

endmodule

// File: doc/jump_target_table.md
Name: jump_target_table

Overview:
- Programmable successor to the fixed branch-target lookup: maps a short jump-label index to a full-width PC target.
- Entries are written at load time by the program loader rather than hard-coded. Each entry carries a valid bit, so a new program image needs no RTL edit.
- Sits between the instruction decoder (label index) and the PC/fetch unit (target).
- Registered read, a hardware clear sequencer and write-to-read forwarding.

Parameters:
- ADDR_W, 5, label index width; DEPTH = 2**ADDR_W entries.
- TGT_W, 12, PC target width.
- MISS_TGT, 0, target returned for an invalid entry.

Ports:
- Clk  input  1  system clock, all state on rising edge
- Reset  input  1  synchronous, active-high reset
- flush  input  1  start a full clear sequence (invalidate all entries)
- wr_en  input  1  write request from loader
- wr_addr  input  ADDR_W  entry to write
- wr_data  input  TGT_W  target value to write
- wr_ready  output  1  table accepts writes this cycle
- rd_en  input  1  lookup request from decoder
- rd_addr  input  ADDR_W  label index
- rd_target  output  TGT_W  registered lookup result
- rd_hit  output  1  registered: entry valid
- busy  output  1  clear sequence in progress

Behaviour:
- Reset values: rd_target=0, rd_hit=0, wr_ready=0, busy=1, FSM=CLEAR, clr_idx=0.
- FSM states:
  - CLEAR: one entry per cycle, valid[clr_idx]<=0 and data[clr_idx]<=0. clr_idx increments. At clr_idx==DEPTH-1, go to READY next cycle, so clearing takes exactly DEPTH cycles. busy=1, wr_ready=0.
  - READY: busy=0, wr_ready=1. flush=1 goes to CLEAR with clr_idx=0.
- Write: accepted only when wr_en & wr_ready. Sets data[wr_addr]<=wr_data and valid[wr_addr]<=1. wr_en while not ready is dropped, not queued.
- Read:
  - rd_en in READY: rd_target/rd_hit update on the next edge (1-cycle latency).
  - Valid entry: rd_target=data, rd_hit=1.
  - Invalid entry: rd_target=MISS_TGT, rd_hit=0.
  - rd_en=0: outputs hold their last value.
  - rd_en during CLEAR: rd_target=MISS_TGT, rd_hit=0.
- Write/read same cycle, same address: the read returns the new wr_data with rd_hit=1 (forwarding). Different addresses are independent.
- flush and wr_en in the same READY cycle: flush wins, the write is discarded, CLEAR starts next cycle.
- flush during CLEAR: restart at clr_idx=0.
- Reset mid-clear or mid-operation: the full reset state applies, no partial retention.
- Widths: entries store TGT_W bits exactly; no sign extension. Addresses cover all DEPTH entries, so there are no out-of-range indices.

Optional Feature:
- Macro: JTT_SEG_OFFSET_EN.
- With the macro defined:
  - Adds inputs base_wr (1) and base_data (TGT_W).
  - A base register (reset 0) loads base_data on base_wr in any state.
  - A valid hit returns rd_target = data + base, modulo 2**TGT_W (wrap, no saturation). A miss returns MISS_TGT with no offset.
  - A base_wr in the same cycle as a read affects that read, because the new base is forwarded.
  - This lets one relative label table serve several program segments.
- Without the macro: the ports are absent, and rd_target = data.

Decomposition:
- Shared package jtt_pkg:
  - default ADDR_W/TGT_W localparams.
  - FSM state enum (JTT_CLEAR, JTT_READY).
  - MISS_TGT default constant.
- One sub-module, jtt_clear_seq: the clr_idx counter plus done pulse, reused by other flushable tables.
- Storage and read path stay in the top module.

Test Plan:
- Reset, then idle: busy=1 for 32 cycles, then busy=0 and wr_ready=1; rd_en to addr 7 gives rd_target=0, rd_hit=0.
- Write addr 3 = 12'd154, then next cycle rd_en addr 3: one cycle later rd_target=154, rd_hit=1.
- Same cycle wr_en addr 17 = 12'd665 and rd_en addr 17: next cycle rd_target=665, rd_hit=1.
- Write addrs 0..4, flush with a simultaneous write to addr 5, wait 32 cycles, read addr 2 and addr 5: both rd_hit=0.
- Reset asserted at clr_idx=10 mid-clear: the clear restarts and busy stays high for a full 32 cycles after deassert.
- With JTT_SEG_OFFSET_EN: write addr 1 = 12'd4000, base=12'd200: read gives rd_target=104 (wrap), rd_hit=1; an invalid addr gives 0.
